// File: rtl/mem_sys_pkg.sv
// Shared types and helpers for the split I/D cache miss controller.
// No logic; latency and backpressure are properties of the users.
package mem_sys_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL_D = 2'd2,
        FILL_I = 2'd3
    } state_t;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/mem_sys_if.sv
// Line-wide request/ack port between the miss controller and unified memory.
// Latency set by memory; request and address hold until the one-cycle ack.
interface mem_sys_if
    import mem_sys_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 4
);
    localparam int LINE_W  = DATA_W * WORDS_PER_LINE;
    localparam int LADDR_W = ADDR_W - off_w(WORDS_PER_LINE);

    logic               mem_re;
    logic               mem_we;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ack;

    modport master (output mem_re, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_re, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/line_word_mux.sv
// Extracts word `sel` from a cache line and builds the line with that word replaced.
// Purely combinational, zero latency; no flow control.
module line_word_mux
    import mem_sys_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int WORDS  = 4,
    localparam int OFF_W  = off_w(WORDS),
    localparam int LINE_W = DATA_W * WORDS
) (
    input  logic [LINE_W-1:0] line,
    input  logic [OFF_W-1:0]  sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] word,
    output logic [LINE_W-1:0] merged
);
    assign word = line[sel*DATA_W +: DATA_W];

    always_comb begin
        merged = line;
        merged[sel*DATA_W +: DATA_W] = wdata;
    end
endmodule

// File: rtl/mem_sys_ctrl.sv
// Miss controller for a direct-mapped I/D cache pair: hits complete same cycle, misses write back then fill.
// Latency: hit 0, miss = mem latency + 1 (+ write-back); ready stays low while any miss is in service.
module mem_sys_ctrl
    import mem_sys_pkg::*;
#(
    parameter  int ADDR_W         = 16,
    parameter  int DATA_W         = 16,
    parameter  int WORDS_PER_LINE = 4,
    parameter  int TAG_W          = 8,
    parameter  int CNT_W          = 16,
    localparam int OFF_W          = off_w(WORDS_PER_LINE),
    localparam int LINE_W         = DATA_W * WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              i_hit,
    input  logic [LINE_W-1:0] i_line,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [TAG_W-1:0]  d_tag,
    input  logic [LINE_W-1:0] d_line,
    output logic              i_we,
    output logic [LINE_W-1:0] i_wline,
    output logic              d_we,
    output logic [LINE_W-1:0] d_wline,
    output logic              d_wdirty,
    mem_sys_if.master         mem,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] readData,
    output logic              ready,
    output logic [CNT_W-1:0]  i_miss_cnt,
    output logic [CNT_W-1:0]  d_miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);
    state_t            state_q;
    logic              i_miss;
    logic              d_miss;
    logic              in_idle;
    logic [LINE_W-1:0] store_base;
    logic [LINE_W-1:0] store_line;
    logic [LINE_W-1:0] unused_i_merged;
    logic [LINE_W-1:0] unused_d_merged;
    logic [DATA_W-1:0] unused_store_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    line_word_mux #(.DATA_W(DATA_W), .WORDS(WORDS_PER_LINE)) u_i_rd (
        .line(i_line), .sel(iaddr[OFF_W-1:0]), .wdata('0),
        .word(instruction), .merged(unused_i_merged)
    );

    line_word_mux #(.DATA_W(DATA_W), .WORDS(WORDS_PER_LINE)) u_d_rd (
        .line(d_line), .sel(daddr[OFF_W-1:0]), .wdata('0),
        .word(readData), .merged(unused_d_merged)
    );

    // Store merge base is the cached line on a hit, the returning fill line otherwise.
    line_word_mux #(.DATA_W(DATA_W), .WORDS(WORDS_PER_LINE)) u_d_st (
        .line(store_base), .sel(daddr[OFF_W-1:0]), .wdata(wdata),
        .word(unused_store_word), .merged(store_line)
    );

    assign in_idle    = (state_q == IDLE);
    assign i_miss     = fetch & ~i_hit;
    assign d_miss     = (re | we) & ~d_hit;
    assign store_base = in_idle ? d_line : mem.mem_rdata;

    assign ready      = ~rst & in_idle & ~i_miss & ~d_miss;
    assign d_we       = ~rst & ((in_idle & we & d_hit) | (state_q == FILL_D & mem.mem_ack));
    assign d_wline    = we ? store_line : mem.mem_rdata;
    assign d_wdirty   = d_we & we;
    assign i_we       = ~rst & (state_q == FILL_I) & mem.mem_ack;
    assign i_wline    = mem.mem_rdata;

    assign mem.mem_re    = ~rst & (state_q == FILL_D | state_q == FILL_I);
    assign mem.mem_we    = ~rst & (state_q == WB);
    assign mem.mem_wdata = d_line;

    always_comb begin
        mem.mem_addr = daddr[ADDR_W-1:OFF_W];
        case (state_q)
            WB:      mem.mem_addr = {d_tag, daddr[ADDR_W-TAG_W-1:OFF_W]};
            FILL_I:  mem.mem_addr = iaddr[ADDR_W-1:OFF_W];
            default: mem.mem_addr = daddr[ADDR_W-1:OFF_W];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_miss_cnt <= '0;
            d_miss_cnt <= '0;
            wb_cnt     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // D side wins; a concurrent I miss is counted now and serviced after the D fill.
                    if (d_miss) begin
                        state_q    <= d_dirty ? WB : FILL_D;
                        d_miss_cnt <= sat_inc(d_miss_cnt);
                        if (d_dirty) wb_cnt     <= sat_inc(wb_cnt);
                        if (i_miss)  i_miss_cnt <= sat_inc(i_miss_cnt);
                    end else if (i_miss) begin
                        state_q    <= FILL_I;
                        i_miss_cnt <= sat_inc(i_miss_cnt);
                    end
                end
                WB:     if (mem.mem_ack) state_q <= FILL_D;
                FILL_D: if (mem.mem_ack) state_q <= i_miss ? FILL_I : IDLE;
                FILL_I: if (mem.mem_ack) state_q <= IDLE;
            endcase
        end
    end
endmodule
